// File: rtl/debug_pkg.sv
// Shared types and constants for the debug dump sequencer: FSM state codes,
// dump phase codes and the default word geometry.
package debug_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int BYTES_PER_WORD = DATA_W_DEF / 8;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_CAP_PC  = 4'd1,
        ST_SET_REG = 4'd2,
        ST_CAP_REG = 4'd3,
        ST_SET_MEM = 4'd4,
        ST_CAP_MEM = 4'd5,
        ST_SEND    = 4'd6,
        ST_GAP     = 4'd7,
        ST_FINISH  = 4'd8
`ifdef DUMP_CHECKSUM_EN
        ,
        ST_CHK     = 4'd9
`endif
    } state_t;

    typedef enum logic [1:0] {
        PH_PC  = 2'd0,
        PH_REG = 2'd1,
        PH_MEM = 2'd2
`ifdef DUMP_CHECKSUM_EN
        ,
        PH_CHK = 2'd3
`endif
    } phase_t;

endpackage

// File: rtl/word_serializer.sv
// Holds one dump word and presents it MSB-first as bytes; each advance shifts
// the next byte to the head. last flags that the head byte ends the word.
module word_serializer #(
    parameter int DATA_W = 32,
    parameter int BPW    = debug_pkg::BYTES_PER_WORD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    input  logic              advance,
    output logic [7:0]        head,
    output logic              last
);

    localparam int CW = (BPW > 1) ? $clog2(BPW) : 1;

    logic [DATA_W-1:0] shift;
    logic [CW-1:0]     cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift <= '0;
            cnt   <= '0;
        end else if (load) begin
            shift <= data;
            cnt   <= '0;
        end else if (advance) begin
            shift <= shift << 8;
            cnt   <= cnt + 1'b1;
        end
    end

    assign head = shift[DATA_W-1 -: 8];
    assign last = (cnt == CW'(BPW - 1));

endmodule

// File: rtl/debug_dump_sequencer.sv
// Streams PC, register file and data memory over the UART TX FIFO, one byte per
// two or more cycles. Define DUMP_CHECKSUM_EN to append an XOR checksum byte.
module debug_dump_sequencer
    import debug_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int REG_ADDR = 5,
    parameter int MEM_ADDR = 5,
    parameter int NUM_REGS = 32,
    parameter int NUM_MEM  = 32
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic                i_tx_full,
    input  logic [DATA_W-1:0]   i_pc,
    input  logic [DATA_W-1:0]   i_reg_data,
    input  logic [DATA_W-1:0]   i_mem_data,
    output logic [REG_ADDR-1:0] o_addr_ID,
    output logic [MEM_ADDR-1:0] o_addr_M,
    output logic [7:0]          o_tx_data,
    output logic                o_wr,
    output logic                o_busy,
    output logic                o_done,
    output state_t              o_state
);

    state_t              state, state_d;
    phase_t              phase, phase_d;
    logic [REG_ADDR-1:0] reg_cnt, reg_cnt_d, addr_id_d;
    logic [MEM_ADDR-1:0] mem_cnt, mem_cnt_d, addr_m_d;
    logic                last_sent, last_sent_d;
    logic [7:0]          tx_d;
    logic                wr_d, busy_d, done_d;
    logic                ser_load, ser_adv, ser_last;
    logic [DATA_W-1:0]   ser_data;
    logic [7:0]          ser_head;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]          chk, chk_d;
`endif

    word_serializer #(.DATA_W(DATA_W), .BPW(DATA_W / 8)) u_ser (
        .clk     (i_clock),
        .rst_n   (i_reset),
        .load    (ser_load),
        .data    (ser_data),
        .advance (ser_adv),
        .head    (ser_head),
        .last    (ser_last)
    );

    always_comb begin
        state_d     = state;
        phase_d     = phase;
        reg_cnt_d   = reg_cnt;
        mem_cnt_d   = mem_cnt;
        last_sent_d = last_sent;
        addr_id_d   = o_addr_ID;
        addr_m_d    = o_addr_M;
        tx_d        = o_tx_data;
        wr_d        = 1'b0;
        busy_d      = o_busy;
        done_d      = 1'b0;
        ser_load    = 1'b0;
        ser_data    = '0;
        ser_adv     = 1'b0;
`ifdef DUMP_CHECKSUM_EN
        chk_d       = chk;
`endif
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_CAP_PC;
                    busy_d  = 1'b1;
                end
            end
            ST_CAP_PC: begin
                ser_load = 1'b1;
                ser_data = i_pc;
                phase_d  = PH_PC;
`ifdef DUMP_CHECKSUM_EN
                chk_d    = 8'h00;
`endif
                state_d  = ST_SEND;
            end
            // Address goes out in SET_x; read data is valid one cycle later.
            ST_SET_REG: begin
                addr_id_d = reg_cnt;
                state_d   = ST_CAP_REG;
            end
            ST_CAP_REG: begin
                ser_load = 1'b1;
                ser_data = i_reg_data;
                phase_d  = PH_REG;
                state_d  = ST_SEND;
            end
            ST_SET_MEM: begin
                addr_m_d = mem_cnt;
                state_d  = ST_CAP_MEM;
            end
            ST_CAP_MEM: begin
                ser_load = 1'b1;
                ser_data = i_mem_data;
                phase_d  = PH_MEM;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                if (!i_tx_full) begin
                    wr_d        = 1'b1;
                    tx_d        = ser_head;
                    ser_adv     = 1'b1;
                    last_sent_d = ser_last;
`ifdef DUMP_CHECKSUM_EN
                    chk_d       = chk ^ ser_head;
`endif
                    state_d     = ST_GAP;
                end
            end
            // One idle cycle after every write lets the FIFO full flag catch up.
            ST_GAP: begin
                if (!last_sent) begin
                    state_d = ST_SEND;
                end else begin
                    case (phase)
                        PH_PC: begin
                            reg_cnt_d = '0;
                            state_d   = ST_SET_REG;
                        end
                        PH_REG: begin
                            if (reg_cnt < REG_ADDR'(NUM_REGS - 1)) begin
                                reg_cnt_d = reg_cnt + 1'b1;
                                state_d   = ST_SET_REG;
                            end else begin
                                mem_cnt_d = '0;
                                state_d   = ST_SET_MEM;
                            end
                        end
                        PH_MEM: begin
                            if (mem_cnt < MEM_ADDR'(NUM_MEM - 1)) begin
                                mem_cnt_d = mem_cnt + 1'b1;
                                state_d   = ST_SET_MEM;
                            end else begin
`ifdef DUMP_CHECKSUM_EN
                                state_d   = ST_CHK;
`else
                                state_d   = ST_FINISH;
`endif
                            end
                        end
                        default: state_d = ST_FINISH;
                    endcase
                end
            end
`ifdef DUMP_CHECKSUM_EN
            ST_CHK: begin
                if (!i_tx_full) begin
                    wr_d        = 1'b1;
                    tx_d        = chk;
                    phase_d     = PH_CHK;
                    last_sent_d = 1'b1;
                    state_d     = ST_GAP;
                end
            end
`endif
            ST_FINISH: begin
                done_d    = 1'b1;
                busy_d    = 1'b0;
                addr_id_d = '0;
                addr_m_d  = '0;
                reg_cnt_d = '0;
                mem_cnt_d = '0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state     <= ST_IDLE;
            phase     <= PH_PC;
            reg_cnt   <= '0;
            mem_cnt   <= '0;
            last_sent <= 1'b0;
            o_addr_ID <= '0;
            o_addr_M  <= '0;
            o_tx_data <= 8'h00;
            o_wr      <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            chk       <= 8'h00;
`endif
        end else begin
            state     <= state_d;
            phase     <= phase_d;
            reg_cnt   <= reg_cnt_d;
            mem_cnt   <= mem_cnt_d;
            last_sent <= last_sent_d;
            o_addr_ID <= addr_id_d;
            o_addr_M  <= addr_m_d;
            o_tx_data <= tx_d;
            o_wr      <= wr_d;
            o_busy    <= busy_d;
            o_done    <= done_d;
`ifdef DUMP_CHECKSUM_EN
            chk       <= chk_d;
`endif
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Bench for debug_dump_sequencer: directed and randomized dumps checked byte by
// byte against a stream model built from the register/memory contents.
module tb_debug_dump_sequencer;
    import debug_pkg::*;

    localparam int NR     = 32;
    localparam int NM     = 32;
`ifdef DUMP_CHECKSUM_EN
    localparam int TOTAL  = (1 + NR + NM) * 4 + 1;
`else
    localparam int TOTAL  = (1 + NR + NM) * 4;
`endif
    localparam int BUDGET = 5000;

    logic        clk;
    logic        i_reset;
    logic        i_start;
    logic        i_tx_full;
    logic [31:0] i_pc;
    logic [31:0] i_reg_data;
    logic [31:0] i_mem_data;
    logic [4:0]  o_addr_ID;
    logic [4:0]  o_addr_M;
    logic [7:0]  o_tx_data;
    logic        o_wr;
    logic        o_busy;
    logic        o_done;
    state_t      o_state;

    logic [31:0] reg_arr [NR];
    logic [31:0] mem_arr [NM];
    logic [7:0]  exp_q[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          byte_cnt = 0;
    int          done_cnt = 0;
    logic [4:0]  prev_id = '0;
    logic [4:0]  prev_m  = '0;
    logic [4:0]  last_id = '0;
    logic [4:0]  last_m  = '0;

    assign i_reg_data = reg_arr[o_addr_ID];
    assign i_mem_data = mem_arr[o_addr_M];

    debug_dump_sequencer dut (
        .i_clock    (clk),
        .i_reset    (i_reset),
        .i_start    (i_start),
        .i_tx_full  (i_tx_full),
        .i_pc       (i_pc),
        .i_reg_data (i_reg_data),
        .i_mem_data (i_mem_data),
        .o_addr_ID  (o_addr_ID),
        .o_addr_M   (o_addr_M),
        .o_tx_data  (o_tx_data),
        .o_wr       (o_wr),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_state    (o_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // reference stream: PC word, each register, each memory word, MSB first
    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) exp_q.push_back(8'((w >> (24 - 8 * b)) & 32'hFF));
    endtask

    task automatic build_expected();
        logic [7:0] x;
        x = 8'h00;
        exp_q.delete();
        push_word(i_pc);
        for (int k = 0; k < NR; k++) push_word(reg_arr[k]);
        for (int k = 0; k < NM; k++) push_word(mem_arr[k]);
`ifdef DUMP_CHECKSUM_EN
        foreach (exp_q[i]) x ^= exp_q[i];
        exp_q.push_back(x);
`endif
    endtask

    task automatic load_directed();
        i_pc = 32'h0000_0040;
        for (int k = 0; k < NR; k++) reg_arr[k] = 32'h1111_0000 + k;
        for (int k = 0; k < NM; k++) mem_arr[k] = 32'hA000_0000 + k;
    endtask

    task automatic load_random();
        i_pc = $urandom;
        for (int k = 0; k < NR; k++) reg_arr[k] = $urandom;
        for (int k = 0; k < NM; k++) mem_arr[k] = $urandom;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_addr_id"}, 32'(o_addr_ID), 0);
        check({tag, "_addr_m"},  32'(o_addr_M),  0);
        check({tag, "_tx_data"}, 32'(o_tx_data), 0);
        check({tag, "_wr"},      32'(o_wr),      0);
        check({tag, "_busy"},    32'(o_busy),    0);
        check({tag, "_done"},    32'(o_done),    0);
    endtask

    // mode 1 = random backpressure; stall/restart/abort are byte indices, -1 = off
    task automatic do_dump(input int mode, input int stall_at, input int restart_at, input int abort_at);
        int base_b;
        int base_d;
        int n;
        int cyc;
        bit stalled;
        bit restarted;
        base_b    = byte_cnt;
        base_d    = done_cnt;
        cyc       = 0;
        stalled   = 1'b0;
        restarted = 1'b0;
        build_expected();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("busy_after_start", 32'(o_busy), 1);
        while (done_cnt == base_d && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            n = byte_cnt - base_b;
            if (mode == 1) i_tx_full = ($urandom_range(0, 3) == 0);
            if (stall_at >= 0 && !stalled && n == stall_at) begin
                stalled   = 1'b1;
                i_tx_full = 1'b1;
                repeat (20) @(negedge clk);
                i_tx_full = 1'b0;
                cyc += 20;
            end
            if (restart_at >= 0 && !restarted && n == restart_at) begin
                restarted = 1'b1;
                i_start   = 1'b1;
                @(negedge clk);
                i_start   = 1'b0;
                cyc++;
            end
            if (abort_at >= 0 && n == abort_at) begin
                #2 i_reset = 1'b0;
                #1 check_outputs_zero("abort");
                repeat (3) @(negedge clk);
                check("abort_no_done", 32'(done_cnt - base_d), 0);
                check("abort_idle_busy", 32'(o_busy), 0);
                exp_q.delete();
                i_tx_full = 1'b0;
                i_reset   = 1'b1;
                return;
            end
        end
        i_tx_full = 1'b0;
        check("dump_completed", 32'(done_cnt != base_d), 1);
        repeat (5) @(negedge clk);
        check("byte_total",      32'(byte_cnt - base_b), TOTAL);
        check("done_once",       32'(done_cnt - base_d), 1);
        check("busy_after_done", 32'(o_busy), 0);
        check("bytes_left",      32'(exp_q.size()), 0);
        check("last_addr_id",    32'(last_id), NR - 1);
        check("last_addr_m",     32'(last_m),  NM - 1);
    endtask

    // scoreboard: sampled 1 ns after each rising edge
    initial begin
        logic [31:0] exp_b;
        forever begin
            @(posedge clk);
            #1;
            if (o_wr) begin
                check("no_wr_while_full", 32'(i_tx_full), 0);
                exp_b = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'h100;
                check("tx_byte", 32'(o_tx_data), exp_b);
                byte_cnt++;
            end
            if (o_done) begin
                done_cnt++;
                check("done_busy_low", 32'(o_busy), 0);
                check("done_all_bytes", 32'(exp_q.size()), 0);
            end
            if (o_busy && o_addr_ID != prev_id) check("addr_id_step", 32'(o_addr_ID), 32'(prev_id) + 1);
            if (o_busy && o_addr_M != prev_m)   check("addr_m_step",  32'(o_addr_M),  32'(prev_m) + 1);
            prev_id = o_addr_ID;
            prev_m  = o_addr_M;
            if (o_busy) begin
                last_id = o_addr_ID;
                last_m  = o_addr_M;
            end
        end
    end

    // directed steps, then randomized dumps
    initial begin
        i_reset   = 1'b1;
        i_start   = 1'b0;
        i_tx_full = 1'b0;
        load_directed();
        #2 i_reset = 1'b0;
        #1 check_outputs_zero("reset");
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_hold");
        i_reset = 1'b1;

        do_dump(0, -1, -1, -1);
        do_dump(0, 26, -1, -1);
        do_dump(0, -1, 50, -1);
        do_dump(0, -1, -1, 100);
        do_dump(0, -1, -1, -1);

        for (int r = 0; r < 3; r++) begin
            load_random();
            do_dump(1, -1, -1, -1);
        end
        load_random();
        do_dump(1, -1, -1, $urandom_range(10, 200));
        do_dump(1, -1, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/debug_dump_sequencer.md
Name: debug_dump_sequencer

Overview:
- Controller that sequences a full debug dump over the UART TX FIFO: the latched PC, then every register-file word, then every data-memory word.
- Each word is serialized MSB-first into bytes.
- Sits between the debug UART interface (which issues the dump command) and the pipeline's register/memory debug read ports.
- Drives the ID-stage and MEM-stage debug read addresses and the UART write strobe.

Parameters:
- DATA_W, 32, width of PC, register and memory words (multiple of 8)
- REG_ADDR, 5, register debug address width
- MEM_ADDR, 5, data-memory debug word address width
- NUM_REGS, 32, registers dumped (addresses 0..NUM_REGS-1, ≤ 2**REG_ADDR)
- NUM_MEM, 32, memory words dumped (addresses 0..NUM_MEM-1, ≤ 2**MEM_ADDR)

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  asynchronous, active-low reset
- i_start  in  1  dump request, one-cycle pulse; sampled only in IDLE
- i_tx_full  in  1  UART TX FIFO full
- i_pc  in  DATA_W  current PC
- i_reg_data  in  DATA_W  register-file read data for o_addr_ID (combinational, valid the cycle after address change)
- i_mem_data  in  DATA_W  memory read data for o_addr_M (same timing)
- o_addr_ID  out  REG_ADDR  register read address
- o_addr_M  out  MEM_ADDR  memory read address
- o_tx_data  out  8  byte to TX FIFO
- o_wr  out  1  TX FIFO write strobe, one cycle per byte
- o_busy  out  1  dump in progress
- o_done  out  1  one-cycle pulse at dump completion

Behaviour:
- Reset (i_reset=0, async): state IDLE; o_addr_ID=0, o_addr_M=0, o_tx_data=0, o_wr=0, o_busy=0, o_done=0; shift register, byte counter and word counters cleared.
- All outputs are registered.
- States: IDLE, CAP_PC, SET_REG, CAP_REG, SET_MEM, CAP_MEM, SEND, GAP, FINISH.
- IDLE:
  - i_start=1 -> CAP_PC; o_busy=1 from the next cycle.
  - i_start in any other state is ignored, with no queuing.
- CAP_PC: shift register <= i_pc; phase=PC -> SEND.
- SET_REG: o_addr_ID <= reg counter -> CAP_REG (one settle cycle).
- CAP_REG: shift <= i_reg_data -> SEND.
- SET_MEM and CAP_MEM: same pattern, using o_addr_M and i_mem_data.
- SEND:
  - If i_tx_full=0: o_wr=1 for one cycle, o_tx_data = shift[DATA_W-1 -: 8]; shift <<= 8; byte counter++; -> GAP.
  - If i_tx_full=1: o_wr=0 and the state holds. No byte is ever written while full.
- GAP: o_wr=0, one cycle so the FIFO full flag updates after each write. Then:
  - bytes left in word -> SEND
  - word complete, phase PC -> SET_REG with reg counter=0
  - phase REG, counter < NUM_REGS-1 -> counter++, SET_REG
  - last reg -> SET_MEM with mem counter=0
  - phase MEM, counter < NUM_MEM-1 -> counter++, SET_MEM
  - last mem word -> FINISH
- FINISH: o_done=1 for one cycle; o_busy=0; addresses reset to 0 -> IDLE.
- Throughput: each byte takes ≥2 cycles. Total bytes = (1+NUM_REGS+NUM_MEM)·DATA_W/8, which is 260 at defaults.
- PC is sampled once, in CAP_PC. A PC change mid-dump is not reflected.
- Reset asserted mid-dump aborts immediately. No partial byte is emitted and no o_done is generated. The next i_start restarts from the PC.
- Counters compare against NUM_x-1 and never wrap past it. NUM_REGS=1 or NUM_MEM=1 are legal.

Optional Feature:
- Macro: DUMP_CHECKSUM_EN.
- Defined:
  - An 8-bit running XOR of every emitted byte is cleared in CAP_PC.
  - After the last memory word's GAP, the state CHK sends the checksum byte, using the same full/GAP rules, before FINISH.
  - Total bytes at defaults = 261.
- Undefined: no CHK state and no checksum register; exactly 260 bytes are sent.

Decomposition:
- Shared package debug_pkg holds:
  - state encoding constants
  - phase codes (PH_PC, PH_REG, PH_MEM)
  - BYTES_PER_WORD = DATA_W/8
- One sub-module, word_serializer: loads DATA_W, emits bytes MSB-first on an advance, and flags last-byte. The FSM stays in debug_dump_sequencer.

Test Plan:
1. Basic dump, checksum disabled:
   - Stimulus: reset, i_pc=0x00000040, reg[k]=0x11110000+k, mem[k]=0xA0000000+k, i_tx_full=0, i_start pulse.
   - Required: 260 o_wr pulses; bytes start 00 00 00 40 11 11 00 00 11 11 00 01 …; last 4 bytes A0 00 00 1F; single o_done; o_busy low afterward.
2. Backpressure:
   - Stimulus: hold i_tx_full=1 for 20 cycles during the 3rd byte of reg 5.
   - Required: no o_wr while full; byte stream identical to scenario 1; no byte lost or duplicated.
3. Start while busy:
   - Stimulus: second i_start at byte 50.
   - Required: ignored; still exactly 260 bytes and one o_done.
4. Reset mid-dump:
   - Stimulus: assert i_reset at byte 100, release, then i_start.
   - Required: all outputs reset within the reset cycle (asynchronous); no o_done; fresh dump begins with the PC bytes.
5. Address timing:
   - Check: o_addr_ID steps 0..31, then o_addr_M steps 0..31.
   - Required: each captured word equals the model value for the address held the preceding cycle.
6. Checksum (DUMP_CHECKSUM_EN):
   - Stimulus: data from scenario 1.
   - Required: 261st byte equals the XOR of the 260 preceding bytes; o_done follows it.
